// File: rtl/den_gt_pkg.sv
// Shared definitions for the den_gt traffic-light family: light bit positions,
// countdown FSM states, 7-segment constants and the light-pattern legality rule.
package den_gt_pkg;

  localparam int unsigned A_RED = 5;
  localparam int unsigned A_YEL = 4;
  localparam int unsigned A_GRN = 3;
  localparam int unsigned B_RED = 2;
  localparam int unsigned B_YEL = 1;
  localparam int unsigned B_GRN = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } cd_state_t;

  // Segment order {g,f,e,d,c,b,a}, active high
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  function automatic logic light_legal(input logic [5:0] l);
    return $onehot({l[A_RED], l[A_YEL], l[A_GRN]}) &&
           $onehot({l[B_RED], l[B_YEL], l[B_GRN]}) &&
           (l[A_RED] || l[B_RED]);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to an active-high 7-segment pattern; codes above 9 go blank.
module bcd_to_7seg
  import den_gt_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/den_gt_countdown.sv
// Countdown display for direction A of den_gt: reloads on each A colour change,
// decrements once per tick, shows two 7-segment digits and flags illegal lights.
module den_gt_countdown
  import den_gt_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_RED    = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] light,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic [6:0] count,
  output logic       fault
);

  localparam int unsigned   PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  cd_state_t     state, state_n;
  logic [5:0]    light_q;
  logic [2:0]    a_prev;
  logic          primed;
  logic [PW-1:0] presc;
  logic          legal, a_chg, tick;
  logic          load, dec, presc_clr;
  logic [6:0]    load_val;
  logic [3:0]    tens_bcd, ones_bcd;
  logic [6:0]    tens_seg, ones_seg;

  // light_q carries its reset value until the first edge after reset, so the
  // FSM only trusts it once primed is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      light_q <= '0;
      a_prev  <= '0;
      primed  <= 1'b0;
      state   <= IDLE;
    end else begin
      light_q <= light;
      a_prev  <= {light_q[A_RED], light_q[A_YEL], light_q[A_GRN]};
      primed  <= 1'b1;
      state   <= state_n;
    end
  end

  assign legal = light_legal(light_q);
  assign a_chg = {light_q[A_RED], light_q[A_YEL], light_q[A_GRN]} != a_prev;
  assign tick  = (presc == PRESC_MAX);

  always_comb begin
    load_val = 7'(T_RED);
    if (light_q[A_GRN])      load_val = 7'(T_GREEN);
    else if (light_q[A_YEL]) load_val = 7'(T_YELLOW);
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    dec       = 1'b0;
    presc_clr = 1'b1;
    unique case (state)
      IDLE: begin
        if (primed) begin
          if (!legal) begin
            state_n = FAULT;
          end else begin
            state_n = RUN;
            load    = 1'b1;
          end
        end
      end
      RUN: begin
        if (!legal) begin
          state_n = FAULT;
        end else if (a_chg) begin
          load = 1'b1;
        end else begin
          presc_clr = 1'b0;
          dec       = tick;
        end
      end
      FAULT: begin
        if (legal) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 presc <= '0;
    else if (presc_clr || tick) presc <= '0;
    else                        presc <= presc + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     count <= '0;
    else if (load)                  count <= load_val;
    else if (dec && count != 7'd0)  count <= count - 7'd1;
  end

  assign tens_bcd = 4'(count / 7'd10);
  assign ones_bcd = 4'(count % 7'd10);

  bcd_to_7seg u_tens (
    .bcd (tens_bcd),
    .seg (tens_seg)
  );

  bcd_to_7seg u_ones (
    .bcd (ones_bcd),
    .seg (ones_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_tens <= '0;
      seg_ones <= '0;
      fault    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          seg_tens <= (count < 7'd10) ? SEG_BLANK : tens_seg;
          seg_ones <= ones_seg;
          fault    <= 1'b0;
        end
        FAULT: begin
          seg_tens <= SEG_DASH;
          seg_ones <= SEG_DASH;
          fault    <= 1'b1;
        end
        default: begin
          seg_tens <= SEG_BLANK;
          seg_ones <= SEG_BLANK;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule
